// File: rtl/spi_sample_master.sv
// Mode-0 SPI master: frames 10-bit samples as {SYNC, seq, 6'b0, sample} and shifts them out MSB first,
// capturing the 32-bit word returned on sdi in the same transfer.
module spi_sample_master #(
    parameter int          CLK_DIV = 4,
    parameter logic [7:0]  SYNC    = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        sck,
    output logic        sdo,
    input  logic        sdi,
    output logic        cs_n,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    output logic [7:0]  seq
);

    localparam int             DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [5:0]     NBITS    = 6'd32;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        DONE
    } state_t;

    state_t            state, state_d;
    logic [DIV_W-1:0]  div, div_d;
    logic [5:0]        bit_cnt, bit_cnt_d;
    logic [31:0]       tx_sr, tx_sr_d;
    logic [31:0]       rx_sr, rx_sr_d;
    logic              tx_ready_d, sck_d, sdo_d, cs_n_d, rx_valid_d;
    logic [31:0]       rx_data_d;
    logic [7:0]        seq_d;
    logic              div_end;

    assign div_end = (div == DIV_LAST);

    // Every output is a register; the comb block computes their next values from the current state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            div      <= '0;
            bit_cnt  <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            tx_ready <= 1'b1;
            sck      <= 1'b0;
            sdo      <= 1'b0;
            cs_n     <= 1'b1;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            seq      <= '0;
        end else begin
            state    <= state_d;
            div      <= div_d;
            bit_cnt  <= bit_cnt_d;
            tx_sr    <= tx_sr_d;
            rx_sr    <= rx_sr_d;
            tx_ready <= tx_ready_d;
            sck      <= sck_d;
            sdo      <= sdo_d;
            cs_n     <= cs_n_d;
            rx_data  <= rx_data_d;
            rx_valid <= rx_valid_d;
            seq      <= seq_d;
        end
    end

    always_comb begin
        state_d    = state;
        div_d      = div;
        bit_cnt_d  = bit_cnt;
        tx_sr_d    = tx_sr;
        rx_sr_d    = rx_sr;
        tx_ready_d = tx_ready;
        sck_d      = sck;
        sdo_d      = sdo;
        cs_n_d     = cs_n;
        rx_data_d  = rx_data;
        rx_valid_d = 1'b0;
        seq_d      = seq;

        case (state)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    tx_sr_d    = {SYNC, seq, 6'd0, tx_data};
                    sdo_d      = SYNC[7];
                    cs_n_d     = 1'b0;
                    tx_ready_d = 1'b0;
                    div_d      = '0;
                    bit_cnt_d  = '0;
                    state_d    = SETUP;
                end
            end

            // SETUP and LOW both end in a rising edge, unless LOW has finished the last bit.
            SETUP, LOW: begin
                if (!div_end) begin
                    div_d = div + DIV_W'(1);
                end else begin
                    div_d = '0;
                    if (state == LOW && bit_cnt == NBITS) begin
                        cs_n_d     = 1'b1;
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_sr;
                        seq_d      = seq + 8'd1;
                        state_d    = DONE;
                    end else begin
                        sck_d     = 1'b1;
                        rx_sr_d   = {rx_sr[30:0], sdi};
                        bit_cnt_d = bit_cnt + 6'd1;
                        state_d   = HIGH;
                    end
                end
            end

            HIGH: begin
                if (!div_end) begin
                    div_d = div + DIV_W'(1);
                end else begin
                    div_d = '0;
                    sck_d = 1'b0;
                    // sdo only moves on the falling edge, and not after the final bit.
                    if (bit_cnt != NBITS) begin
                        tx_sr_d = {tx_sr[30:0], 1'b0};
                        sdo_d   = tx_sr[30];
                    end
                    state_d = LOW;
                end
            end

            DONE: begin
                tx_ready_d = 1'b1;
                state_d    = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_sample_master.sv
// Bench for spi_sample_master: a behavioural SPI slave on a CLK_DIV=4 instance and a loopback
// CLK_DIV=1 instance, with expected frames built from the frame-format rule and a model sequence count.
module tb_spi_sample_master;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  tx_data = '0, tx_data1 = '0;
    logic        tx_valid = 1'b0, tx_valid1 = 1'b0;
    logic        tx_ready, sck, sdo, cs_n, rx_valid;
    logic        tx_ready1, sck1, sdo1, cs_n1, rx_valid1, sdi1;
    logic        sdi = 1'b0;
    logic [31:0] rx_data, rx_data1;
    logic [7:0]  seq, seq1;

    always #5 clk = ~clk;

    spi_sample_master #(.CLK_DIV(4), .SYNC(8'hA5)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .sck(sck), .sdo(sdo), .sdi(sdi), .cs_n(cs_n), .rx_data(rx_data), .rx_valid(rx_valid), .seq(seq)
    );

    spi_sample_master #(.CLK_DIV(1), .SYNC(8'hA5)) dut1 (
        .clk(clk), .reset(reset), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
        .sck(sck1), .sdo(sdo1), .sdi(sdi1), .cs_n(cs_n1), .rx_data(rx_data1), .rx_valid(rx_valid1), .seq(seq1)
    );

    // Loopback: the word received must equal the word sent.
    assign sdi1 = sdo1;

    int passed = 0, total = 0, cyc = 0;

    function automatic logic [31:0] frame(input logic [7:0] s, input logic [9:0] d);
        return {8'hA5, s, 6'd0, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    always @(posedge clk) cyc++;

    // Mode-0 slave: samples sdo on sck rise, presents s_word MSB first, advancing on sck fall.
    logic [31:0] s_word = '0, s_rx = '0;
    logic [9:0]  voltage = '0;
    int          s_bit = 0, s_rises = 0;
    always @(negedge cs_n) begin s_bit = 31; sdi = s_word[31]; s_rises = 0; end
    always @(posedge sck) begin s_rx = {s_rx[30:0], sdo}; s_rises++; end
    always @(negedge sck) if (!cs_n && s_bit > 0) begin s_bit--; sdi = s_word[s_bit]; end
    always @(posedge cs_n) voltage = s_rx[9:0];

    int rxv0 = 0, bad_sck = 0;
    always @(negedge clk) begin
        if (rx_valid) rxv0++;
        if ((sck && cs_n) || (sck1 && cs_n1)) bad_sck++;
    end

    // Scoreboard for the loopback instance.
    logic [31:0] q1[$];
    logic [31:0] exp1, last_rx1 = '0;
    logic [7:0]  m_seq1 = '0;
    int acc1 = 0, done1 = 0, rx_bad1 = 0, seq_bad1 = 0, rdy_bad1 = 0, sp_bad = 0, unexp1 = 0, last_acc = -1;
    bit in1 = 0, b2b = 0;
    always @(negedge clk) begin
        if (!reset) begin
            q1.delete(); m_seq1 = '0; in1 = 0; last_acc = -1; acc1 = 0; done1 = 0;
        end else begin
            if (rx_valid1) begin
                if (q1.size() == 0) unexp1++;
                else begin exp1 = q1.pop_front(); if (rx_data1 !== exp1) rx_bad1++; end
                last_rx1 = rx_data1;
                m_seq1++;
                if (seq1 !== m_seq1) seq_bad1++;
                in1 = 0;
                done1++;
            end
            if (in1 && tx_ready1) rdy_bad1++;
            if (tx_valid1 && tx_ready1) begin
                q1.push_back(frame(m_seq1, tx_data1));
                if (b2b && last_acc >= 0 && cyc - last_acc != 67) sp_bad++;
                last_acc = cyc;
                acc1++;
                in1 = 1;
            end
        end
    end

    initial begin
        int n, viol;
        logic [9:0]  d;
        logic [31:0] w;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_sck", sck, 0);
        chk("rst_sdo", sdo, 0);
        chk("rst_cs_n", cs_n, 1);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_seq", seq, 0);
        @(negedge clk) reset = 1'b1;

        viol = 0;
        repeat (100) begin @(negedge clk); if (sck !== 1'b0 || cs_n !== 1'b1) viol++; end
        chk("idle_quiet", viol, 0);

        // Frame 2B5 at CLK_DIV=4 with a stray tx_valid pulse and tx_data change mid-frame.
        @(posedge clk); #1;
        s_word = $urandom; w = s_word;
        tx_data = 10'h2B5; tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0; tx_data = 10'($urandom);
        chk("accept_cs_n", cs_n, 0);
        chk("accept_sdo_msb", sdo, 1);
        n = 0;
        while (n < 1000) begin
            @(posedge clk); #1; n++;
            if (n == 50) tx_valid = 1'b1;
            if (n == 60) tx_valid = 1'b0;
            if (rx_valid) break;
        end
        // rx_valid is visible in the 261st cycle after the accept edge: 65*4 edges later.
        chk("latency_cd4", n, 260);
        chk("done_tx_ready", tx_ready, 0);
        chk("done_cs_n", cs_n, 1);
        chk("sdo_bits", s_rx, 32'hA50002B5);
        chk("rise_count", s_rises, 32);
        chk("rx_data_slave", rx_data, w);
        chk("seq_after", seq, 1);
        chk("voltage", voltage, 10'h2B5);
        @(posedge clk); #1;
        chk("ready_back", tx_ready, 1);
        chk("rx_valid_pulse", rx_valid, 0);
        repeat (20) @(posedge clk); #1;
        chk("no_extra_frame", cs_n, 1);
        chk("rx_valid_count", rxv0, 1);

        // CLK_DIV=1 single frame, loopback.
        d = 10'($urandom);
        tx_data1 = d; tx_valid1 = 1'b1;
        @(posedge clk); #1;
        tx_valid1 = 1'b0;
        n = 0;
        while (n < 500) begin @(posedge clk); #1; n++; if (rx_valid1) break; end
        chk("latency_cd1", n, 65);
        chk("cd1_data", rx_data1, frame(8'd0, d));
        chk("cd1_seq", seq1, 1);

        // Reset at the 15th rise abandons the frame.
        @(posedge clk); #1;
        s_word = $urandom;
        tx_data = 10'($urandom); tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        n = 0;
        while (s_rises < 15 && n < 2000) begin @(negedge clk); n++; end
        chk("reached_rise15", s_rises, 15);
        reset = 1'b0;
        #1;
        chk("abort_sck", sck, 0);
        chk("abort_cs_n", cs_n, 1);
        chk("abort_seq", seq, 0);
        chk("abort_rx_valid", rx_valid, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (300) @(negedge clk);
        chk("abort_no_rx_valid", rxv0, 1);

        @(posedge clk); #1;
        s_word = $urandom; w = s_word;
        d = 10'($urandom);
        tx_data = d; tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        n = 0;
        while (n < 1000) begin @(posedge clk); #1; n++; if (rx_valid) break; end
        chk("post_abort_latency", n, 260);
        chk("post_abort_sdo", s_rx, frame(8'd0, d));
        chk("post_abort_rx", rx_data, w);
        chk("post_abort_voltage", voltage, d);
        chk("post_abort_seq", seq, 1);

        // 257 back-to-back frames on the CLK_DIV=1 instance, tx_valid held high.
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        b2b = 1;
        tx_valid1 = 1'b1; tx_data1 = 10'($urandom);
        n = 0;
        while (acc1 < 257 && n < 20000) begin @(posedge clk); #1; tx_data1 = 10'($urandom); n++; end
        tx_valid1 = 1'b0;
        n = 0;
        while (done1 < 257 && n < 200) begin @(posedge clk); #1; n++; end
        chk("b2b_accepts", acc1, 257);
        chk("b2b_done", done1, 257);
        chk("b2b_data_errs", rx_bad1, 0);
        chk("b2b_seq_errs", seq_bad1, 0);
        chk("b2b_ready_errs", rdy_bad1, 0);
        chk("b2b_spacing_errs", sp_bad, 0);
        chk("b2b_unexpected", unexp1, 0);
        chk("b2b_queue_left", q1.size(), 0);
        chk("b2b_last_seq_field", last_rx1[23:16], 0);
        chk("b2b_seq_wrap", seq1, 1);
        chk("sck_high_outside_frame", bad_sck, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
